// File: rtl/decode_if.sv
// Bus between fetch/writeback and the LC3 decode stage.
// The fetch side drives the master modport and the decode stage uses the slave modport.
interface decode_if;
  // Handshake: enable_decode is valid and !stall is ready. An instruction transfers
  // on a posedge where enable_decode=1 and stall=0. While stall=1 the producer holds
  // dout/npc_in unchanged. stall never depends on a same-cycle transfer.
  logic        enable_decode;
  logic [15:0] dout;
  logic [15:0] npc_in;
  logic        wb_en;
  logic [2:0]  wb_dr;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [2:0]  dr;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control;
  logic        out_valid;
  logic        stall;

  modport master (
    output enable_decode, dout, npc_in, wb_en, wb_dr,
    input  IR, npc_out, dr, sr1, sr2, E_Control, W_Control, Mem_Control, out_valid, stall
  );

  modport slave (
    input  enable_decode, dout, npc_in, wb_en, wb_dr,
    output IR, npc_out, dr, sr1, sr2, E_Control, W_Control, Mem_Control, out_valid, stall
  );
endinterface

// File: rtl/decode.sv
// LC3 decode stage: registers the instruction and emits register addresses and control words.
// Define DECODE_SCOREBOARD_EN to add per-register busy tracking that stalls on pending writebacks.
module decode (
  input  logic     clk,
  input  logic     rst,
  decode_if.slave  bus
);
  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  logic [1:0]  alu_op;
  logic [1:0]  pcsel1;
  logic        pcsel2;
  logic        op2sel;
  logic [1:0]  w_ctl;
  logic        mem_ctl;
  logic        writes_dr;
  logic        uses_sr1;
  logic        uses_sr2;
  logic [2:0]  sr2_sel;
  logic        stall;
  logic        accept;

  logic [15:0] ir_q, ir_d;
  logic [15:0] npc_q, npc_d;
  logic [2:0]  sr2_q, sr2_d;
  logic [5:0]  e_ctl_q, e_ctl_d;
  logic [1:0]  w_ctl_q, w_ctl_d;
  logic        mem_ctl_q, mem_ctl_d;
  logic        valid_q, valid_d;

  // Decode the incoming word so stall can be computed before it is accepted.
  always_comb begin
    alu_op    = 2'b00;
    pcsel1    = 2'b00;
    pcsel2    = 1'b0;
    op2sel    = 1'b0;
    w_ctl     = 2'd0;
    mem_ctl   = 1'b0;
    writes_dr = 1'b0;
    uses_sr1  = 1'b0;
    uses_sr2  = 1'b0;
    sr2_sel   = 3'd0;
    case (bus.dout[15:12])
      OP_ADD, OP_AND: begin
        alu_op    = (bus.dout[15:12] == OP_AND) ? 2'b01 : 2'b00;
        op2sel    = ~bus.dout[5];
        writes_dr = 1'b1;
        uses_sr1  = 1'b1;
        uses_sr2  = ~bus.dout[5];
        sr2_sel   = bus.dout[2:0];
      end
      OP_NOT: begin
        alu_op    = 2'b10;
        writes_dr = 1'b1;
        uses_sr1  = 1'b1;
      end
      OP_LD, OP_LDI: begin
        pcsel1    = 2'b01;
        pcsel2    = 1'b1;
        w_ctl     = 2'd1;
        mem_ctl   = (bus.dout[15:12] == OP_LDI);
        writes_dr = 1'b1;
      end
      OP_LDR: begin
        pcsel1    = 2'b10;
        w_ctl     = 2'd1;
        writes_dr = 1'b1;
        uses_sr1  = 1'b1;
      end
      OP_LEA: begin
        pcsel1    = 2'b01;
        pcsel2    = 1'b1;
        w_ctl     = 2'd2;
        writes_dr = 1'b1;
      end
      OP_ST, OP_STI: begin
        pcsel1    = 2'b01;
        pcsel2    = 1'b1;
        mem_ctl   = (bus.dout[15:12] == OP_STI);
        uses_sr2  = 1'b1;
        sr2_sel   = bus.dout[11:9];
      end
      OP_STR: begin
        pcsel1    = 2'b10;
        uses_sr1  = 1'b1;
        uses_sr2  = 1'b1;
        sr2_sel   = bus.dout[11:9];
      end
      OP_BR: begin
        pcsel1    = 2'b01;
        pcsel2    = 1'b1;
      end
      OP_JMP: begin
        pcsel1    = 2'b11;
        uses_sr1  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef DECODE_SCOREBOARD_EN
  logic [7:0] busy_q, busy_d;

  // Only registered busy is consulted, so a writeback frees the reader one cycle later.
  assign stall = bus.enable_decode &
                 ((uses_sr1 & busy_q[bus.dout[8:6]]) | (uses_sr2 & busy_q[sr2_sel]));

  always_comb begin
    busy_d = busy_q;
    if (bus.wb_en) busy_d[bus.wb_dr] = 1'b0;
    if (accept && writes_dr) busy_d[bus.dout[11:9]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end
`else
  logic unused_sb;
  assign stall     = 1'b0;
  assign unused_sb = ^{writes_dr, uses_sr1, uses_sr2, bus.wb_en, bus.wb_dr};
`endif

  assign accept = bus.enable_decode & ~stall;

  always_comb begin
    ir_d      = ir_q;
    npc_d     = npc_q;
    sr2_d     = sr2_q;
    e_ctl_d   = e_ctl_q;
    w_ctl_d   = w_ctl_q;
    mem_ctl_d = mem_ctl_q;
    valid_d   = 1'b0;
    if (accept) begin
      ir_d      = bus.dout;
      npc_d     = bus.npc_in;
      sr2_d     = sr2_sel;
      e_ctl_d   = {alu_op, pcsel1, pcsel2, op2sel};
      w_ctl_d   = w_ctl;
      mem_ctl_d = mem_ctl;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q      <= '0;
      npc_q     <= '0;
      sr2_q     <= '0;
      e_ctl_q   <= '0;
      w_ctl_q   <= '0;
      mem_ctl_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      ir_q      <= ir_d;
      npc_q     <= npc_d;
      sr2_q     <= sr2_d;
      e_ctl_q   <= e_ctl_d;
      w_ctl_q   <= w_ctl_d;
      mem_ctl_q <= mem_ctl_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.IR          = ir_q;
  assign bus.npc_out     = npc_q;
  assign bus.dr          = ir_q[11:9];
  assign bus.sr1         = ir_q[8:6];
  assign bus.sr2         = sr2_q;
  assign bus.E_Control   = e_ctl_q;
  assign bus.W_Control   = w_ctl_q;
  assign bus.Mem_Control = mem_ctl_q;
  assign bus.out_valid   = valid_q;
  assign bus.stall       = stall;
endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: opcode-table model checked every cycle plus literal pins.
// Scoreboard scenarios are compiled in when DECODE_SCOREBOARD_EN is defined.
module tb_decode;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic cmp_on;
  logic stall_seen;

  decode_if bus ();

  decode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- opcode tables (index = opcode) ----------------
  int alu_tab [16] = '{0,0,0,0, 0,1,0,0, 0,2,0,0, 0,0,0,0};
  int p1_tab  [16] = '{1,0,1,1, 0,0,2,2, 0,0,1,1, 3,0,1,0};
  int p2_tab  [16] = '{1,0,1,1, 0,0,0,0, 0,0,1,1, 0,0,1,0};
  int w_tab   [16] = '{0,0,1,0, 0,0,1,0, 0,0,1,0, 0,0,2,0};
  int wr_tab  [16] = '{0,1,1,0, 0,1,1,0, 0,1,1,0, 0,0,1,0};
  int u1_tab  [16] = '{0,1,0,0, 0,1,1,1, 0,1,0,0, 1,0,0,0};

  // ---------------- behavioural model ----------------
  logic [15:0] m_ir, m_npc;
  logic [2:0]  m_sr2;
  logic [5:0]  m_e;
  logic [1:0]  m_w;
  logic        m_m, m_valid;
  logic [7:0]  m_busy;

  task automatic model_decode(input logic [15:0] ins, output logic [5:0] e, output logic [1:0] w,
                              output logic m, output logic [2:0] s2, output logic wr,
                              output logic u1, output logic u2);
    int   op;
    logic alu3, store;
    op    = int'(ins[15:12]);
    alu3  = (op == 1) || (op == 5);
    store = (op == 3) || (op == 7) || (op == 11);
    e     = {2'(alu_tab[op]), 2'(p1_tab[op]), 1'(p2_tab[op]), alu3 & ~ins[5]};
    w     = 2'(w_tab[op]);
    m     = (op == 10) || (op == 11);
    s2    = alu3 ? ins[2:0] : (store ? ins[11:9] : 3'd0);
    wr    = 1'(wr_tab[op]);
    u1    = 1'(u1_tab[op]);
    u2    = store | (alu3 & ~ins[5]);
  endtask

  task automatic model_stall(output logic st);
    logic [5:0] e; logic [1:0] w; logic m, wr, u1, u2; logic [2:0] s2;
    model_decode(bus.dout, e, w, m, s2, wr, u1, u2);
`ifdef DECODE_SCOREBOARD_EN
    st = bus.enable_decode & ((u1 & m_busy[bus.dout[8:6]]) | (u2 & m_busy[s2]));
`else
    st = 1'b0;
`endif
  endtask

  always @(posedge clk) begin
    logic [5:0] e; logic [1:0] w; logic m, wr, u1, u2, st, acc; logic [2:0] s2;
    if (rst) begin
      m_ir = '0; m_npc = '0; m_sr2 = '0; m_e = '0; m_w = '0; m_m = 1'b0;
      m_valid = 1'b0; m_busy = '0;
    end else begin
      model_decode(bus.dout, e, w, m, s2, wr, u1, u2);
      model_stall(st);
      acc = bus.enable_decode & ~st;
      m_valid = acc;
      if (acc) begin
        m_ir = bus.dout; m_npc = bus.npc_in; m_sr2 = s2; m_e = e; m_w = w; m_m = m;
      end
      if (bus.wb_en) m_busy[bus.wb_dr] = 1'b0;
      if (acc && wr) m_busy[bus.dout[11:9]] = 1'b1;
    end
  end

  // ---------------- scoreboard checks ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic st;
    if (cmp_on) begin
      model_stall(st);
      chk("m_ir",    bus.IR, m_ir);
      chk("m_npc",   bus.npc_out, m_npc);
      chk("m_dr",    16'(bus.dr), 16'(m_ir[11:9]));
      chk("m_sr1",   16'(bus.sr1), 16'(m_ir[8:6]));
      chk("m_sr2",   16'(bus.sr2), 16'(m_sr2));
      chk("m_e",     16'(bus.E_Control), 16'(m_e));
      chk("m_w",     16'(bus.W_Control), 16'(m_w));
      chk("m_mem",   16'(bus.Mem_Control), 16'(m_m));
      chk("m_valid", 16'(bus.out_valid), 16'(m_valid));
      chk("m_stall", 16'(bus.stall), 16'(st));
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic en, input logic [15:0] d, input logic [15:0] npc,
                      input logic we, input logic [2:0] wd);
    bus.enable_decode = en;
    bus.dout          = d;
    bus.npc_in        = npc;
    bus.wb_en         = we;
    bus.wb_dr         = wd;
    #1;
    stall_seen = bus.stall;
    @(posedge clk);
    #2;
  endtask

  logic [15:0] vec [10] = '{16'h5A65, 16'h5642, 16'h9A7F, 16'hC1C0, 16'h0E05,
                            16'h3A10, 16'hB7FF, 16'h2401, 16'h6C83, 16'hF025};

  initial begin
    total = 0; bad = 0; cmp_on = 1'b0; stall_seen = 1'b0;
    rst = 1'b1;
    bus.enable_decode = 1'b0; bus.dout = '0; bus.npc_in = '0; bus.wb_en = 1'b0; bus.wb_dr = '0;
    @(posedge clk); #2;
    cmp_on = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;

    chk("rst_ir",    bus.IR, 16'h0000);
    chk("rst_npc",   bus.npc_out, 16'h0000);
    chk("rst_e",     16'(bus.E_Control), 16'h0000);
    chk("rst_w",     16'(bus.W_Control), 16'h0000);
    chk("rst_valid", 16'(bus.out_valid), 16'h0000);
    chk("rst_stall", 16'(bus.stall), 16'h0000);

    step(1'b1, 16'h1242, 16'h3001, 1'b0, 3'd0);
    chk("add_ir",    bus.IR, 16'h1242);
    chk("add_npc",   bus.npc_out, 16'h3001);
    chk("add_dr",    16'(bus.dr), 16'd1);
    chk("add_sr1",   16'(bus.sr1), 16'd1);
    chk("add_sr2",   16'(bus.sr2), 16'd2);
    chk("add_e",     16'(bus.E_Control), 16'(6'b000001));
    chk("add_w",     16'(bus.W_Control), 16'd0);
    chk("add_valid", 16'(bus.out_valid), 16'd1);
    step(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 3'd0);
    chk("hold_ir",    bus.IR, 16'h1242);
    chk("hold_valid", 16'(bus.out_valid), 16'd0);

    step(1'b1, 16'hE605, 16'h3002, 1'b0, 3'd0);
    chk("lea_w", 16'(bus.W_Control), 16'd2);
    chk("lea_e", 16'(bus.E_Control), 16'(6'b000110));
    step(1'b1, 16'hA002, 16'h3003, 1'b0, 3'd0);
    chk("ldi_w", 16'(bus.W_Control), 16'd1);
    chk("ldi_m", 16'(bus.Mem_Control), 16'd1);
    step(1'b1, 16'h7941, 16'h3004, 1'b0, 3'd0);
    chk("str_sr2", 16'(bus.sr2), 16'd4);
    chk("str_e",   16'(bus.E_Control), 16'(6'b001000));

    step(1'b1, 16'hD123, 16'h3005, 1'b0, 3'd0);
    chk("rsv_valid", 16'(bus.out_valid), 16'd1);
    chk("rsv_e",     16'(bus.E_Control), 16'd0);
    chk("rsv_w",     16'(bus.W_Control), 16'd0);
    chk("rsv_m",     16'(bus.Mem_Control), 16'd0);

    // Mixed opcode sweep with writebacks interleaved; the model covers every cycle.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, vec[i], 16'h4000 + 16'(i), i[0], 3'(i));
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 3'(i + 3));
    end
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0000, 16'h0000, 1'b1, 3'(i));

`ifdef DECODE_SCOREBOARD_EN
    rst = 1'b1; step(1'b0, 16'h0000, 16'h0000, 1'b0, 3'd0); rst = 1'b0;
    step(1'b1, 16'h2401, 16'h5000, 1'b0, 3'd0);
    chk("sb_ld_valid", 16'(bus.out_valid), 16'd1);
    step(1'b1, 16'h1283, 16'h5001, 1'b0, 3'd0);
    chk("sb_stall1", 16'(stall_seen), 16'd1);
    chk("sb_hold_ir", bus.IR, 16'h2401);
    chk("sb_hold_valid", 16'(bus.out_valid), 16'd0);
    step(1'b1, 16'h1283, 16'h5001, 1'b1, 3'd2);
    chk("sb_stall_wb", 16'(stall_seen), 16'd1);
    step(1'b1, 16'h1283, 16'h5001, 1'b0, 3'd0);
    chk("sb_unstall", 16'(stall_seen), 16'd0);
    chk("sb_add_ir", bus.IR, 16'h1283);
    step(1'b1, 16'h2401, 16'h5002, 1'b1, 3'd2);
    step(1'b1, 16'h1283, 16'h5003, 1'b1, 3'd5);
    chk("sb_set_wins", 16'(stall_seen), 16'd1);
    rst = 1'b1; step(1'b1, 16'h1283, 16'h5003, 1'b0, 3'd0); rst = 1'b0;
    step(1'b1, 16'h1283, 16'h5003, 1'b0, 3'd0);
    chk("sb_rst_unstall", 16'(stall_seen), 16'd0);
    step(1'b1, 16'h2801, 16'h5004, 1'b1, 3'd4);
    step(1'b1, 16'hD400, 16'h5005, 1'b1, 3'd1);
    step(1'b1, 16'h1683, 16'h5006, 1'b0, 3'd0);
    chk("sb_rsv_nobusy", 16'(stall_seen), 16'd0);
    chk("sb_rsv_ir", bus.IR, 16'h1683);
`else
    step(1'b1, 16'h2401, 16'h5000, 1'b0, 3'd0);
    step(1'b1, 16'h1283, 16'h5001, 1'b0, 3'd0);
    chk("nosb_nostall", 16'(stall_seen), 16'd0);
    chk("nosb_add_ir", bus.IR, 16'h1283);
    rst = 1'b1; step(1'b1, 16'h1283, 16'h5003, 1'b0, 3'd0); rst = 1'b0;
    chk("midrst_ir", bus.IR, 16'h0000);
`endif
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 3'd0);
    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
